// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// default baud divider used by both the TX and RX directions.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage : uart_pkg

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input; every stage
// resets to RESET_VAL so an idle-high line does not look like an edge.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : sync_ff

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised input, mid-bit sampling with a per-phase
// down-counter, and a valid/ack output register with overrun/framing flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int                TICK_W      = $clog2(CLKS_PER_BIT);
    localparam int                IDX_W       = $clog2(DATA_BITS);
    localparam logic [TICK_W-1:0] TICK_FULL   = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] TICK_HALF   = TICK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(DATA_BITS - 1);
    localparam logic [TICK_W-1:0] TICK_ONE    = TICK_W'(1);
    localparam logic [IDX_W-1:0]  IDX_ONE     = IDX_W'(1);

    logic rxs;

    rx_state_t              state_q,     state_d;
    logic [TICK_W-1:0]      tick_q,      tick_d;
    logic [IDX_W-1:0]       bit_idx_q,   bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q,     shift_d;
    logic [DATA_BITS-1:0]   rx_data_q,   rx_data_d;
    logic                   rx_valid_q,  rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q,   overrun_d;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // An ack retires the held byte unless a commit below re-asserts valid.
        if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    tick_d  = TICK_HALF;
                end
            end
            START: begin
                if (tick_q != '0) begin
                    tick_d = tick_q - TICK_ONE;
                end else if (!rxs) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tick_d    = TICK_FULL;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (tick_q != '0) begin
                    tick_d = tick_q - TICK_ONE;
                end else begin
                    shift_d[bit_idx_q] = rxs;
                    tick_d             = TICK_FULL;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_ONE;
                    end
                end
            end
            STOP: begin
                if (tick_q != '0) begin
                    tick_d = tick_q - TICK_ONE;
                end else if (rxs) begin
                    // Leaving at mid-stop-bit lets a back-to-back start edge be seen.
                    rx_data_d  = shift_q;
                    rx_valid_d = 1'b1;
                    overrun_d  = rx_valid_q && !rx_ack;
                    state_d    = IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = BREAK;
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: a table of single frames
// plus hand-written sequences for latency, glitch, back-to-back, overrun and reset.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int passCount  = 0;
    int checkCount = 0;
    int frameErrCount = 0;
    int overrunCount  = 0;
    int busyCount     = 0;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        int         holdLow;
        logic [7:0] expData;
        logic       expValid;
        int         expFrameErr;
    } vec_t;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle so checks can compare before/after deltas.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) frameErrCount++;
            if (overrun)   overrunCount++;
            if (busy)      busyCount++;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            tick(CPB);
        end
        rx = stopBit;
        tick(CPB);
    endtask

    task automatic ackPulse();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
    endtask

    vec_t vecs[6];
    int   feBefore;
    int   ovBefore;
    int   busyBefore;
    int   latency;
    logic [7:0] got[2];
    int   gotCount;

    initial begin
        vecs[0] = '{8'h3C, 1'b0, 40, 8'hA5, 1'b0, 1};
        vecs[1] = '{8'h55, 1'b1,  0, 8'h55, 1'b1, 0};
        vecs[2] = '{8'h00, 1'b1,  0, 8'h00, 1'b1, 0};
        vecs[3] = '{8'hFF, 1'b1,  0, 8'hFF, 1'b1, 0};
        vecs[4] = '{8'h80, 1'b0, 10, 8'hFF, 1'b0, 1};
        vecs[5] = '{8'h01, 1'b1,  0, 8'h01, 1'b1, 0};

        rst    = 1'b1;
        rx     = 1'b1;
        rx_ack = 1'b0;
        tick(3);
        checkOutput("reset rx_data",   32'(rx_data),   32'h0);
        checkOutput("reset rx_valid",  32'(rx_valid),  32'h0);
        checkOutput("reset frame_err", 32'(frame_err), 32'h0);
        checkOutput("reset overrun",   32'(overrun),   32'h0);
        checkOutput("reset busy",      32'(busy),      32'h0);
        rst = 1'b0;
        tick(4);

        // 0xA5 with latency measured from the falling start edge.
        latency = 0;
        fork
            applyStimulus(8'hA5, 1'b1);
            begin
                while (!rx_valid && latency < 300) begin
                    @(posedge clk);
                    #1;
                    latency++;
                end
            end
        join
        rx = 1'b1;
        checkCount++;
        if (latency >= 154 && latency <= 156) passCount++;
        else $display("[TB] FAIL latency: got %0d cycles expected 155 +/-1", latency);
        @(negedge clk);
        checkOutput("A5 rx_data",  32'(rx_data),  32'hA5);
        checkOutput("A5 rx_valid", 32'(rx_valid), 32'h1);
        tick(1);
        ackPulse();
        @(negedge clk);
        checkOutput("A5 rx_valid after ack", 32'(rx_valid), 32'h0);
        tick(4);

        foreach (vecs[v]) begin
            feBefore = frameErrCount;
            applyStimulus(vecs[v].data, vecs[v].stopBit);
            if (vecs[v].holdLow > 0) begin
                rx = 1'b0;
                tick(vecs[v].holdLow);
            end
            rx = 1'b1;
            tick(8);
            @(negedge clk);
            checkOutput($sformatf("vec%0d rx_data", v), 32'(rx_data), 32'(vecs[v].expData));
            checkOutput($sformatf("vec%0d rx_valid", v), 32'(rx_valid), 32'(vecs[v].expValid));
            checkOutput($sformatf("vec%0d frame_err pulses", v), 32'(frameErrCount - feBefore),
                        32'(vecs[v].expFrameErr));
            checkOutput($sformatf("vec%0d busy idle", v), 32'(busy), 32'h0);
            tick(1);
            if (vecs[v].expValid) begin
                ackPulse();
                @(negedge clk);
                checkOutput($sformatf("vec%0d ack clears", v), 32'(rx_valid), 32'h0);
                tick(1);
            end
        end

        // Glitch shorter than half a bit: START rejects it after 8 busy cycles.
        feBefore   = frameErrCount;
        busyBefore = busyCount;
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(30);
        @(negedge clk);
        checkOutput("glitch busy cycles", 32'(busyCount - busyBefore), 32'd8);
        checkOutput("glitch rx_valid",    32'(rx_valid),               32'h0);
        checkOutput("glitch frame_err",   32'(frameErrCount - feBefore), 32'h0);
        checkOutput("glitch busy idle",   32'(busy),                   32'h0);
        tick(1);

        // Back-to-back frames with a consumer acking each byte.
        ovBefore = overrunCount;
        gotCount = 0;
        got[0]   = 8'h00;
        got[1]   = 8'h00;
        fork
            begin
                applyStimulus(8'h01, 1'b1);
                applyStimulus(8'hFF, 1'b1);
                rx = 1'b1;
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    int waitCycles = 0;
                    @(negedge clk);
                    while (!rx_valid && waitCycles < 400) begin
                        @(negedge clk);
                        waitCycles++;
                    end
                    if (rx_valid) begin
                        got[k] = rx_data;
                        gotCount++;
                    end
                    rx_ack = 1'b1;
                    @(negedge clk);
                    rx_ack = 1'b0;
                end
            end
        join
        tick(8);
        checkOutput("b2b byte count", 32'(gotCount), 32'd2);
        checkOutput("b2b first byte",  32'(got[0]), 32'h01);
        checkOutput("b2b second byte", 32'(got[1]), 32'hFF);
        checkOutput("b2b overrun",     32'(overrunCount - ovBefore), 32'h0);

        // Overrun: two bytes without any ack.
        ovBefore = overrunCount;
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        rx = 1'b1;
        tick(8);
        @(negedge clk);
        checkOutput("overrun pulses",   32'(overrunCount - ovBefore), 32'd1);
        checkOutput("overrun rx_data",  32'(rx_data),  32'h22);
        checkOutput("overrun rx_valid", 32'(rx_valid), 32'h1);
        tick(1);

        // Ack landing exactly on the commit edge (start edge + 154) suppresses overrun.
        ovBefore = overrunCount;
        fork
            applyStimulus(8'h44, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1 rx_ack = 1'b1;
                @(posedge clk);
                #1 rx_ack = 1'b0;
            end
        join
        rx = 1'b1;
        tick(4);
        @(negedge clk);
        checkOutput("ack-commit overrun",  32'(overrunCount - ovBefore), 32'h0);
        checkOutput("ack-commit rx_data",  32'(rx_data),  32'h44);
        checkOutput("ack-commit rx_valid", 32'(rx_valid), 32'h1);
        tick(1);

        // Reset during data bit 3 of 0x7E, then a clean 0x42.
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = (8'h7E >> i) & 8'h01;
            tick(CPB);
        end
        rx = 1'b1;
        tick(CPB / 2);
        checkOutput("pre-reset busy", 32'(busy), 32'h1);
        rst = 1'b1;
        tick(1);
        checkOutput("mid-reset rx_data",  32'(rx_data),  32'h0);
        checkOutput("mid-reset rx_valid", 32'(rx_valid), 32'h0);
        checkOutput("mid-reset busy",     32'(busy),     32'h0);
        rst = 1'b0;
        tick(4);
        applyStimulus(8'h42, 1'b1);
        rx = 1'b1;
        tick(8);
        @(negedge clk);
        checkOutput("post-reset rx_data",  32'(rx_data),  32'h42);
        checkOutput("post-reset rx_valid", 32'(rx_valid), 32'h1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_uart_rx

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side counterpart of the existing UART transmitter.
- Deserialises an asynchronous 8N1 serial line (idle high, LSB first) into bytes.
- Presents each byte to the consumer with a valid/ack handshake.
- Sits between the board RX pin and the PDP-8 console/TTY input logic; pairs with the TX path for loopback testing.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per bit period; must be ≥ 4. Test uses 16; synthesis sets it from clock and baud.
- SYNC_STAGES, 2, number of flops in the input synchroniser; must be ≥ 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial input; idles at 1.
- rx_data  output  8  last good received byte; stable while rx_valid=1.
- rx_valid  output  1  byte available; held until acknowledged.
- rx_ack  input  1  consumer takes the byte; ignored when rx_valid=0.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- overrun  output  1  one-cycle pulse when a new byte lands while rx_valid=1 with no ack that cycle.
- busy  output  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, bit counter=0, synchroniser flops=1.
- rx passes through SYNC_STAGES flops. rxs is the synchronised value; all decisions use rxs only.
- Single down-counter `tick` reloads per phase. HALF = CLKS_PER_BIT/2 (integer division).
- IDLE: when rxs=0 → START, tick=HALF-1.
- START: on tick=0, sample rxs.
  - rxs=0 → DATA, bit index=0, tick=CLKS_PER_BIT-1.
  - rxs=1 → IDLE (glitch rejected; no flags).
- DATA: on tick=0, shift rxs into bit[index] (LSB first). Index 7 → STOP, else index+1. Reload tick each bit.
- STOP: on tick=0, sample rxs.
  - rxs=1 → commit byte, go to IDLE.
  - rxs=0 → frame_err pulse, byte discarded, rx_data unchanged → BREAK.
- BREAK: wait for rxs=1, then IDLE. A held-low line produces exactly one frame_err.
- The FSM returns to IDLE at mid-stop-bit, so back-to-back frames with no idle gap are received.
- Commit cycle (registered, visible the cycle after the stop sample):
  - rx_data ← shift register; rx_valid ← 1.
  - If rx_valid was 1 and rx_ack=0 in the commit cycle: overrun pulses and the new byte overwrites the old one.
  - If rx_ack=1 in the commit cycle: no overrun; rx_valid stays 1 with the new byte.
- rx_ack=1 while rx_valid=1 and no commit that cycle: rx_valid ← 0 next cycle.
- Latency: rx_valid rises SYNC_STAGES + HALF + 9×CLKS_PER_BIT + 1 cycles (±1 for edge phase) after the falling start edge at the pin.
- busy=1 in START, DATA, STOP and BREAK.
- rst asserted mid-frame: everything returns to reset values next cycle and any partial byte is lost. After reset release, a line already low is treated as a start edge. This is an accepted hazard; the consumer discards the first byte after reset if needed.
- No parity, 1 stop bit only, no baud auto-detect.

Decomposition:
- Shared package uart_pkg holds:
  - state enum rx_state_t {IDLE, START, DATA, STOP, BREAK};
  - DATA_BITS=8;
  - the default CLKS_PER_BIT constant, shared with the TX side so both directions agree on baud.
- One sub-module, sync_ff (parameter STAGES, reset value 1), used for the rx synchroniser. It is reusable for other async inputs.
- The FSM, counters, shift register and output registers live in uart_rx itself.

Test Plan:
- Single byte 0xA5 at 16 clk/bit, frame 0,1,0,1,0,0,1,0,1,1 → rx_valid rises ~155 cycles after the start edge, rx_data=0xA5. Assert rx_ack for one cycle → rx_valid=0 next cycle.
- Glitch: rx low for 5 cycles, then high → FSM returns to IDLE, no rx_valid, no frame_err; busy was 1 only during the glitch window.
- Framing: send 0x3C with stop bit=0, then hold rx low 40 cycles → exactly one frame_err pulse, rx_data keeps its prior value, rx_valid stays 0. After rx rises, 0x55 is received normally.
- Back-to-back 0x01, 0xFF with no idle gap, rx_ack pulsed after each valid → both bytes received in order, no overrun.
- Overrun: send 0x11 then 0x22 with no ack → one overrun pulse at the second commit, rx_data=0x22, rx_valid=1. Repeat with rx_ack=1 in the commit cycle → no overrun.
- Reset mid-frame: assert rst during bit 3 of 0x7E → outputs return to reset values next cycle. Release with rx idle high, then send 0x42 → rx_data=0x42.
